// File: rtl/ac_coeff_scan_sequencer.sv
// AC coefficient scan sequencer: walks a slice's coefficient RAM in
// position-major / block-minor order (positions 1..63), counts zero runs
// and hands one (run, level) token per nonzero coefficient downstream.
module ac_coeff_scan_sequencer (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [3:0]         num_blocks,
  output logic               busy,
  output logic               done,
  output logic               coeff_rd_en,
  output logic [8:0]         coeff_addr,
  input  logic signed [31:0] coeff_rd_data,
  output logic               tok_valid,
  input  logic               tok_ready,
  output logic [31:0]        tok_run,
  output logic signed [31:0] tok_level,
  output logic               tok_first,
  output logic [9:0]         tok_count
);

  typedef enum logic [2:0] {IDLE, RD, CHK, EMIT, DONE} state_t;

  state_t state, state_next;

  logic [5:0]         pos, pos_next;
  logic [2:0]         blk, blk_next;
  logic [3:0]         nb, nb_next;
  logic [8:0]         run, run_next;
  logic               first, first_next;

  // Token fields; the run is at most 503 so 9 bits are kept and zero-extended.
  logic [8:0]         tok_run_q, tok_run_next;
  logic signed [31:0] tok_level_next;
  logic               tok_first_next;
  logic               tok_valid_next;
  logic [9:0]         tok_count_next;

  logic [3:0]         nb_clamped;
  logic               blk_wrap;
  logic               last_coeff;
  logic [5:0]         adv_pos;
  logic [2:0]         adv_blk;
  state_t             adv_state;

  assign tok_run = {23'd0, tok_run_q};

  // Clamp the requested block count to 1..8 and precompute the scan advance.
  always_comb begin
    nb_clamped = num_blocks;
    if (num_blocks == 4'd0) begin
      nb_clamped = 4'd1;
    end else if (num_blocks > 4'd8) begin
      nb_clamped = 4'd8;
    end
    blk_wrap   = ({1'b0, blk} == (nb - 4'd1));
    last_coeff = blk_wrap && (pos == 6'd63);
    adv_blk    = blk_wrap ? 3'd0 : blk + 3'd1;
    adv_pos    = blk_wrap ? pos + 6'd1 : pos;
    adv_state  = last_coeff ? DONE : RD;
  end

  // Next-state and next-register logic for the scan FSM.
  always_comb begin
    state_next     = state;
    pos_next       = pos;
    blk_next       = blk;
    nb_next        = nb;
    run_next       = run;
    first_next     = first;
    tok_run_next   = tok_run_q;
    tok_level_next = tok_level;
    tok_first_next = tok_first;
    tok_valid_next = tok_valid;
    tok_count_next = tok_count;

    case (state)
      IDLE: begin
        if (start) begin
          nb_next        = nb_clamped;
          pos_next       = 6'd1;
          blk_next       = 3'd0;
          run_next       = 9'd0;
          first_next     = 1'b1;
          tok_count_next = 10'd0;
          state_next     = RD;
        end
      end
      RD: begin
        state_next = CHK;
      end
      CHK: begin
        if (coeff_rd_data != 32'sd0) begin
          tok_run_next   = run;
          tok_level_next = coeff_rd_data;
          tok_first_next = first;
          tok_valid_next = 1'b1;
          run_next       = 9'd0;
          first_next     = 1'b0;
          state_next     = EMIT;
        end else begin
          run_next   = run + 9'd1;
          pos_next   = adv_pos;
          blk_next   = adv_blk;
          state_next = adv_state;
        end
      end
      EMIT: begin
        if (tok_ready) begin
          tok_valid_next = 1'b0;
          tok_count_next = tok_count + 10'd1;
          pos_next       = adv_pos;
          blk_next       = adv_blk;
          state_next     = adv_state;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and scan-position registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pos   <= 6'd0;
      blk   <= 3'd0;
      nb    <= 4'd0;
      run   <= 9'd0;
      first <= 1'b0;
    end else begin
      state <= state_next;
      pos   <= pos_next;
      blk   <= blk_next;
      nb    <= nb_next;
      run   <= run_next;
      first <= first_next;
    end
  end

  // Registered outputs, decoded from the state being entered so they line
  // up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      coeff_rd_en <= 1'b0;
      coeff_addr  <= 9'd0;
      tok_valid   <= 1'b0;
      tok_run_q   <= 9'd0;
      tok_level   <= 32'sd0;
      tok_first   <= 1'b0;
      tok_count   <= 10'd0;
    end else begin
      busy        <= (state_next != IDLE);
      done        <= (state_next == DONE);
      coeff_rd_en <= (state_next == RD);
      if (state_next == RD) begin
        coeff_addr <= {blk_next, pos_next};
      end
      tok_valid   <= tok_valid_next;
      tok_run_q   <= tok_run_next;
      tok_level   <= tok_level_next;
      tok_first   <= tok_first_next;
      tok_count   <= tok_count_next;
    end
  end

endmodule

// File: tb/tb_ac_coeff_scan_sequencer.sv
// Scoreboard bench for ac_coeff_scan_sequencer: expected tokens are queued
// by the stimulus branch and popped by a monitor on every accepted token.
module tb_ac_coeff_scan_sequencer;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [3:0]         num_blocks;
  logic               busy;
  logic               done;
  logic               coeff_rd_en;
  logic [8:0]         coeff_addr;
  logic signed [31:0] coeff_rd_data = 32'sd0;
  logic               tok_valid;
  logic               tok_ready;
  logic [31:0]        tok_run;
  logic signed [31:0] tok_level;
  logic               tok_first;
  logic [9:0]         tok_count;

  always #5 clk = ~clk;

  ac_coeff_scan_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_blocks(num_blocks),
    .busy(busy), .done(done), .coeff_rd_en(coeff_rd_en), .coeff_addr(coeff_addr),
    .coeff_rd_data(coeff_rd_data), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_run(tok_run), .tok_level(tok_level), .tok_first(tok_first),
    .tok_count(tok_count)
  );

  // Coefficient RAM model with one-cycle registered read.
  logic signed [31:0] mem [0:511];
  always @(posedge clk) if (coeff_rd_en) coeff_rd_data <= mem[coeff_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int run; int level; int first; } tok_t;
  tok_t exp_q[$];

  int total = 0, bad = 0;
  int start_cyc, exp_done, cur_nb, rd_cnt, done_seen, done_cyc, k, ntok;
  int busy_bad, addr_bad, stab_bad;
  bit active = 1'b0;
  logic        prev_valid, prev_ready, prev_first;
  logic [31:0] prev_run, prev_level;

  function automatic int a(input int b, input int p);
    return b * 64 + p;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 32'sd0;
  endtask

  task automatic push(input int r, input int l, input int f);
    tok_t t;
    t.run = r; t.level = l; t.first = f;
    exp_q.push_back(t);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [3:0] nb_in);
    step(); start = 1'b1; num_blocks = nb_in;
    step(); start_cyc = cyc; start = 1'b0; num_blocks = 4'd0;
  endtask

  // Run one slice; bp = cycles of held-off ready on the first token,
  // glitch = cycle offset of an extra start pulse while busy (0 = none).
  task automatic run_slice(input string name, input logic [3:0] nb_in, input int eff_nb,
                           input int exp_d, input int exp_cnt, input int bp, input int glitch);
    int n;
    busy_bad = 0; addr_bad = 0; stab_bad = 0; rd_cnt = 0;
    done_seen = 0; done_cyc = 0; cur_nb = eff_nb; exp_done = exp_d;
    tok_ready = (bp == 0);
    pulse_start(nb_in);
    active = 1'b1;
    if (bp > 0) begin
      n = 0;
      while (!tok_valid && n < 2000) begin step(); n++; end
      check({name, "_first_valid"}, tok_valid, 1);
      repeat (bp) step();
      tok_ready = 1'b1;
    end
    if (glitch > 0) begin
      repeat (glitch) step();
      start = 1'b1; num_blocks = 4'd1;
      step();
      start = 1'b0; num_blocks = 4'd0;
    end
    n = 0;
    while (done_seen == 0 && n < 3000) begin step(); n++; end
    repeat (2) step();
    active = 1'b0;
    check({name, "_done_seen"}, done_seen, 1);
    check({name, "_done_cycle"}, done_cyc, exp_d);
    check({name, "_tok_count"}, tok_count, exp_cnt);
    check({name, "_tokens_left"}, exp_q.size(), 0);
    check({name, "_reads"}, rd_cnt, 63 * eff_nb);
    check({name, "_addr_errs"}, addr_bad, 0);
    check({name, "_busy_errs"}, busy_bad, 0);
    check({name, "_stable_errs"}, stab_bad, 0);
    exp_q.delete();
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; num_blocks = 4'd0; tok_ready = 1'b0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_first = 1'b0;
    prev_run = '0; prev_level = '0; ntok = 0;
    clear_mem();
    fork
      // Monitor: per-cycle checks and scoreboard pops on accepted tokens.
      begin
        forever begin
          @(negedge clk);
          if (reset_n && active) begin
            k = cyc - start_cyc + 1;
            if (busy !== ((k >= 1) && (k <= exp_done))) busy_bad++;
            if (coeff_rd_en) begin
              if (coeff_addr != 9'(((rd_cnt % cur_nb) * 64) + (rd_cnt / cur_nb) + 1)) addr_bad++;
              if (tok_valid) stab_bad++;
              rd_cnt++;
            end
            if (tok_valid && prev_valid && !prev_ready &&
                ({tok_run, tok_level, tok_first} != {prev_run, prev_level, prev_first}))
              stab_bad++;
            if (tok_valid && tok_ready) begin
              ntok++;
              $display("tok %0d: cycle=%0d run=%0d level=%0d first=%0d",
                       ntok, k, tok_run, tok_level, tok_first);
              if (exp_q.size() == 0) begin
                check("unexpected_token", 1, 0);
              end else begin
                tok_t e;
                e = exp_q.pop_front();
                check("tok_run", tok_run, e.run);
                check("tok_level", tok_level, e.level);
                check("tok_first", tok_first, e.first);
              end
            end
            if (done) begin done_seen++; done_cyc = k; end
          end
          prev_valid = tok_valid; prev_ready = tok_ready;
          prev_run = tok_run; prev_level = tok_level; prev_first = tok_first;
        end
      end
      // Stimulus.
      begin
        int n;
        repeat (3) step();
        check("reset_outputs", {busy, done, coeff_rd_en, coeff_addr, tok_valid,
                                tok_run, tok_level, tok_first, tok_count}, 0);
        reset_n = 1'b1;
        step();

        // Reset while a token is pending under backpressure.
        mem[a(0,1)] = 5; mem[a(1,1)] = -3; mem[a(0,3)] = 1;
        tok_ready = 1'b0;
        pulse_start(4'd2);
        n = 0;
        while (!tok_valid && n < 100) begin step(); n++; end
        check("rst_pre_valid", tok_valid, 1);
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        check("rst_mid_outputs", {busy, done, coeff_rd_en, coeff_addr, tok_valid,
                                  tok_run, tok_level, tok_first, tok_count}, 0);
        repeat (2) step();
        reset_n = 1'b1;
        step();

        // nb=1 after reset: tokens at positions 1 and 63.
        clear_mem();
        mem[a(0,1)] = 7; mem[a(0,63)] = -2;
        push(0, 7, 1); push(61, -2, 0);
        run_slice("after_rst", 4'd1, 1, 129, 2, 0, 0);

        // All-zero slice.
        clear_mem();
        run_slice("all_zero", 4'd1, 1, 127, 0, 0, 0);

        // Scan order and runs, free-flowing, backpressured, and with a stray start.
        mem[a(0,1)] = 5; mem[a(1,1)] = -3; mem[a(0,3)] = 1;
        push(0, 5, 1); push(0, -3, 0); push(2, 1, 0);
        run_slice("scan", 4'd2, 2, 256, 3, 0, 0);
        push(0, 5, 1); push(0, -3, 0); push(2, 1, 0);
        run_slice("backpr", 4'd2, 2, 266, 3, 10, 0);
        push(0, 5, 1); push(0, -3, 0); push(2, 1, 0);
        run_slice("start_busy", 4'd2, 2, 256, 3, 0, 50);

        // Maximum run, and clamping of oversized block count.
        clear_mem();
        mem[a(7,63)] = 100;
        push(503, 100, 1);
        run_slice("nb8", 4'd8, 8, 1010, 1, 0, 0);
        push(503, 100, 1);
        run_slice("nb12", 4'd12, 8, 1010, 1, 0, 0);

        // nb=0 acts as nb=1: block 1 must never be read.
        clear_mem();
        mem[a(0,63)] = 9; mem[a(1,5)] = 4;
        push(62, 9, 1);
        run_slice("nb0", 4'd0, 1, 128, 1, 0, 0);
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ac_coeff_scan_sequencer.md
# ac_coeff_scan_sequencer

Slice-level controller that drives the AC level/run entropy path. It walks a slice's quantised coefficient RAM in ProRes AC scan order: every coefficient position 1..63 in turn, and within each position every block of the slice. It counts zero runs and hands one (run, level) token per nonzero coefficient to the downstream run and level encoders over a valid/ready handshake. It also marks the first token of each slice so the level encoder can reset its adaptive `previousLevel` state.

## Interface
Parameters:
- none; all widths are fixed.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to encode one slice; sampled only in IDLE.
- `num_blocks`  in  4  number of blocks in the slice; sampled with `start`; 0 is clamped to 1 and values above 8 are clamped to 8.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  high for exactly the one cycle spent in DONE.
- `coeff_rd_en`  out  1  coefficient RAM read strobe.
- `coeff_addr`  out  9  RAM address = {blk[2:0], pos[5:0]}.
- `coeff_rd_data`  in  32 (signed)  RAM data; valid exactly one cycle after `coeff_rd_en`.
- `tok_valid`  out  1  token valid.
- `tok_ready`  in  1  downstream accepts the token.
- `tok_run`  out  32  number of zero coefficients preceding this one in scan order (zero-extended; maximum 503).
- `tok_level`  out  32 (signed)  nonzero coefficient value, passed through unmodified.
- `tok_first`  out  1  set on the first token of the slice.
- `tok_count`  out  10  tokens accepted in the current or most recent slice.

## Operation
- Internal registers: `pos` (6 b), `blk` (3 b), latched `nb` (4 b), `run` (9 b), `first` (1 b).
- Every output is a register. Reset value of every output is 0.
- FSM states: IDLE, RD, CHK, EMIT, DONE.
- **IDLE**
  - On `start`: latch the clamped `nb`; set `pos`=1, `blk`=0, `run`=0, `first`=1; clear `tok_count`; go to RD.
- **RD**
  - Assert `coeff_rd_en`=1 with `coeff_addr`={blk,pos} for this cycle only; go to CHK.
- **CHK** (`coeff_rd_data` is valid)
  - If data ≠ 0: load `tok_run`=`run`, `tok_level`=data, `tok_first`=`first`; set `tok_valid`=1; then `run`=0 and `first`=0; go to EMIT.
  - Otherwise: `run`=`run`+1, then advance.
- **EMIT**
  - Hold `tok_valid` and all `tok_*` fields stable and issue no reads until `tok_ready`=1.
  - On the accepting edge: `tok_valid`=0, `tok_count`+1, then advance.
- **Advance**
  - If `blk`=`nb`−1: `blk`=0 and `pos`+1; otherwise `blk`+1.
  - If the coefficient just handled was the last one (`pos`=63 and `blk`=`nb`−1), go to DONE; otherwise go to RD.
- **DONE**
  - `done`=1 for this one cycle; go to IDLE.
  - `tok_count` holds until the next `start`.
- Trailing zeros after the last nonzero coefficient produce no token. An all-zero slice produces no tokens at all.
- DC (position 0) is never read.
- `start` is ignored while `busy`=1.
- Reset asserted at any point mid-slice returns the block to IDLE at once with all outputs 0. Any pending token is dropped and never reappears.

## Timing
- Cycle 1 is the first cycle after the edge that samples `start`.
- Each coefficient costs 2 cycles (RD, CHK), plus at least 1 EMIT cycle per nonzero coefficient.
- Let Z = 63·nb coefficients and E = total EMIT cycles. Then:
  - `done` is high in cycle 2Z+E+1;
  - `busy` is high in cycles 1..2Z+E+1.
- With `tok_ready` held at 1, each token is accepted in its first EMIT cycle, so E equals the number of nonzero coefficients.
- Read-to-use latency is fixed at 1 cycle. RAM wait states are not supported.
- `tok_valid` rises the cycle after CHK and falls the cycle after the accepting edge. It is never high for two tokens back-to-back, because a minimum of 2 cycles of RD/CHK separates tokens.

## Test plan
- **Reset:** drive `reset_n`=0 in the middle of a slice (inside EMIT with `tok_ready`=0) → all outputs 0 immediately. After release, `start` with `nb`=1 runs normally from `pos`=1.
- **All-zero slice:** `nb`=1, all-zero RAM, `tok_ready`=1 → no `tok_valid`; `done` in cycle 127; `tok_count`=0; 63 reads at addresses 1..63.
- **Scan order and runs:** `nb`=2 with RAM[{0,1}]=5, RAM[{1,1}]=−3, RAM[{0,3}]=1, all else 0 → tokens in order:
  - (run 0, level 5, first 1);
  - (run 0, level −3, first 0);
  - (run 2, level 1, first 0);
  - then `tok_count`=3 and `done` in cycle 2·126+3+1=256.
- **Backpressure:** in the previous scenario, hold `tok_ready`=0 for 10 cycles on the first token → fields stay stable, `coeff_rd_en` stays 0, and `done` moves 10 cycles later.
- **Maximum run and clamping:** `nb`=8 (and separately `nb`=12) with only RAM[{7,63}]=100 → a single token (run 503, level 100, first 1). `nb`=0 behaves identically to `nb`=1.
- **Start while busy:** pulse `start` mid-slice → no effect on addresses, tokens or `done` timing.
